// File: rtl/mips_multicycle_datapath.sv
// Multicycle MIPS subset datapath: FETCH/DECODE/EXEC/MEM/WB FSM with internal imem, dmem and register file.
// Optional macro MIPS_JUMP_EN adds the j instruction (opcode 0x02).
module mips_multicycle_datapath #(
  parameter int          IMEM_DEPTH = 256,
  parameter int          DMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        MemRead,
  output logic [31:0] ReadData2,
  output logic [31:0] ALU_Result,
  output logic [2:0]  state,
  output logic        instr_done,
  output logic        halted
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd7
  } state_t;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

  logic [31:0] im [IMEM_DEPTH];
  logic [31:0] dm [DMEM_DEPTH];
  logic [31:0] rf [32];

  state_t      state_q;
  logic [31:0] pc_q, ir_q, a_q, b_q, alu_q, mdr_q;
  logic        rw_q, mw_q, mr_q, done_q, halted_q;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, dest;
  logic [31:0] sext, alu_d, wb_val;
  logic        legal;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign funct = ir_q[5:0];
  assign sext  = {{16{ir_q[15]}}, ir_q[15:0]};
  assign dest  = (op == OP_R) ? rd : rt;
  assign wb_val = (op == OP_LW) ? mdr_q : alu_q;

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_R:                          legal = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
      OP_LW, OP_SW, OP_BEQ, OP_ADDI: legal = 1'b1;
`ifdef MIPS_JUMP_EN
      OP_J:                          legal = 1'b1;
`endif
      default:                       legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_d = a_q + sext;
    case (op)
      OP_R: begin
        case (funct)
          F_SUB:   alu_d = a_q - b_q;
          F_AND:   alu_d = a_q & b_q;
          F_OR:    alu_d = a_q | b_q;
          F_SLT:   alu_d = {31'd0, $signed(a_q) < $signed(b_q)};
          default: alu_d = a_q + b_q;
        endcase
      end
      OP_BEQ:  alu_d = a_q - b_q;
      default: alu_d = a_q + sext;
    endcase
  end

  // Strobes are registered one state ahead so they are high exactly in the committing state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      alu_q    <= '0;
      mdr_q    <= '0;
      rw_q     <= 1'b0;
      mw_q     <= 1'b0;
      mr_q     <= 1'b0;
      done_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      rw_q   <= 1'b0;
      mw_q   <= 1'b0;
      mr_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        FETCH: begin
          ir_q    <= im[pc_q[IAW+1:2]];
          pc_q    <= pc_q + 32'd4;
          state_q <= DECODE;
        end
        DECODE: begin
          a_q <= (rs == 5'd0) ? 32'd0 : rf[rs];
          b_q <= (rt == 5'd0) ? 32'd0 : rf[rt];
          if (!legal) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else begin
            state_q <= EXEC;
            done_q  <= (op == OP_BEQ) || (op == OP_J);
          end
        end
        EXEC: begin
          alu_q <= alu_d;
          case (op)
            OP_LW: begin
              state_q <= MEM;
              mr_q    <= 1'b1;
            end
            OP_SW: begin
              state_q <= MEM;
              mw_q    <= 1'b1;
              done_q  <= 1'b1;
            end
            OP_BEQ: begin
              if (a_q == b_q) pc_q <= pc_q + {sext[29:0], 2'b00};
              state_q <= FETCH;
            end
`ifdef MIPS_JUMP_EN
            OP_J: begin
              pc_q    <= {pc_q[31:28], ir_q[25:0], 2'b00};
              state_q <= FETCH;
            end
`endif
            default: begin
              state_q <= WB;
              rw_q    <= 1'b1;
              done_q  <= 1'b1;
            end
          endcase
        end
        MEM: begin
          mdr_q <= dm[alu_q[DAW+1:2]];
          if (mr_q) begin
            state_q <= WB;
            rw_q    <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            state_q <= FETCH;
          end
        end
        WB:      state_q <= FETCH;
        HALT:    state_q <= HALT;
        default: state_q <= HALT;
      endcase
    end
  end

  // Storage commits are gated by rst so a reset edge always wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (!rst && state_q == MEM && mw_q) dm[alu_q[DAW+1:2]] <= b_q;
    if (!rst && state_q == WB && rw_q && dest != 5'd0) rf[dest] <= wb_val;
  end

  assign pc          = pc_q;
  assign instruction = ir_q;
  assign RegWrite    = rw_q;
  assign MemWrite    = mw_q;
  assign MemRead     = mr_q;
  assign ReadData2   = b_q;
  assign ALU_Result  = alu_q;
  assign state       = state_q;
  assign instr_done  = done_q;
  assign halted      = halted_q;
endmodule

// File: tb/tb_mips_multicycle_datapath.sv
// Scoreboard bench for mips_multicycle_datapath: stimulus queues expected events, a monitor checks them.
module tb_mips_multicycle_datapath;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] pc, instruction, ReadData2, ALU_Result;
  logic        RegWrite, MemWrite, MemRead, instr_done, halted;
  logic [2:0]  state;

  always #5 clk = ~clk;

  mips_multicycle_datapath dut (
    .clk(clk), .rst(rst), .pc(pc), .instruction(instruction),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead),
    .ReadData2(ReadData2), .ALU_Result(ALU_Result), .state(state),
    .instr_done(instr_done), .halted(halted)
  );

  // kind: 0 reset-state, 1 retired instruction, 2 halt entry; sk: 0 none, 1 reg, 2 dmem
  typedef struct {
    int          kind;
    string       name;
    int          cyc;
    int          rw_n;
    int          mr_c;
    int          mw_c;
    logic [31:0] pc;
    int          sk;
    int          idx;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] stor(input int sk, input int idx);
    return (sk == 1) ? dut.rf[idx] : dut.dm[idx];
  endfunction

  task automatic take(input int kind, output exp_t e, output bit ok);
    checks++;
    ok = 1'b0;
    e  = '{kind: -1, name: "none", cyc: 0, rw_n: 0, mr_c: 0, mw_c: 0, pc: '0, sk: 0, idx: 0, val: '0};
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL event_kind%0d: got unexpected event, required none", kind);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind) begin
        errors++;
        $display("FAIL %s: got event kind %0d required kind %0d", e.name, kind, e.kind);
      end else ok = 1'b1;
    end
  endtask

  // Monitor
  initial begin
    int   cyc = 0, rw_n = 0, mr_c = 0, mw_c = 0, hcnt = 0, hbad = 0, hmin = 0;
    bit   hmon = 0, post = 0, hprev = 0, ok;
    logic [31:0] hpc = '0;
    exp_t e, pr;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (hmon) chk("halt_hold", 32'((hbad == 0) && (hcnt >= hmin)), 32'd1);
        cyc = 0; rw_n = 0; mr_c = 0; mw_c = 0; hmon = 0; post = 0; hprev = 0;
      end else begin
        cyc++;
        if (RegWrite) rw_n++;
        if (MemRead)  mr_c = cyc;
        if (MemWrite) mw_c = cyc;
        if (post) begin
          chk({pr.name, ".pc"}, pc, pr.pc);
          if (pr.sk != 0) chk({pr.name, ".store"}, stor(pr.sk, pr.idx), pr.val);
          post = 0;
        end
        if (hmon) begin
          hcnt++;
          if (pc !== hpc || RegWrite || MemWrite || MemRead || instr_done || state !== 3'd7 || !halted)
            hbad++;
        end
        if (cyc == 1) begin
          take(0, e, ok);
          if (ok) begin
            chk({e.name, ".state"}, 32'(state), 32'd0);
            chk({e.name, ".pc"}, pc, 32'h0);
            chk({e.name, ".instr"}, instruction, 32'h0);
            chk({e.name, ".alu_rd2"}, ALU_Result | ReadData2, 32'h0);
            chk({e.name, ".strobes"}, 32'({RegWrite, MemWrite, MemRead, instr_done, halted}), 32'd0);
            if (e.sk != 0) chk({e.name, ".store"}, stor(e.sk, e.idx), e.val);
          end
        end
        if (instr_done) begin
          take(1, e, ok);
          if (ok) begin
            chk({e.name, ".cyc"}, 32'(cyc), 32'(e.cyc));
            chk({e.name, ".rw_n"}, 32'(rw_n), 32'(e.rw_n));
            chk({e.name, ".mr_cyc"}, 32'(mr_c), 32'(e.mr_c));
            chk({e.name, ".mw_cyc"}, 32'(mw_c), 32'(e.mw_c));
            pr = e;
            post = 1;
          end
          rw_n = 0; mr_c = 0; mw_c = 0;
        end
        if (halted && !hprev) begin
          take(2, e, ok);
          if (ok) begin
            chk({e.name, ".cyc"}, 32'(cyc), 32'(e.cyc));
            chk({e.name, ".state"}, 32'(state), 32'd7);
            chk({e.name, ".pc"}, pc, e.pc);
            hmon = 1; hcnt = 0; hbad = 0; hpc = e.pc; hmin = e.idx;
          end
        end
        hprev = halted;
      end
    end
  end

  function automatic logic [31:0] rty(input logic [4:0] rs, rt, rd, input logic [5:0] f);
    return {6'd0, rs, rt, rd, 5'd0, f};
  endfunction
  function automatic logic [31:0] ity(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic e_rst(input string n, input int sk, input int idx, input logic [31:0] val);
    sb.push_back('{kind: 0, name: n, cyc: 1, rw_n: 0, mr_c: 0, mw_c: 0, pc: '0, sk: sk, idx: idx, val: val});
  endtask
  task automatic e_done(input string n, input int cyc, input int rw_n, input int mr_c, input int mw_c,
                        input logic [31:0] p, input int sk, input int idx, input logic [31:0] val);
    sb.push_back('{kind: 1, name: n, cyc: cyc, rw_n: rw_n, mr_c: mr_c, mw_c: mw_c, pc: p, sk: sk, idx: idx, val: val});
  endtask
  task automatic e_halt(input string n, input int cyc, input logic [31:0] p, input int hold);
    sb.push_back('{kind: 2, name: n, cyc: cyc, rw_n: 0, mr_c: 0, mw_c: 0, pc: p, sk: 0, idx: hold, val: '0});
  endtask

  task automatic rst_on();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic go(input int n);
    rst = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clr();
    for (int i = 0; i < 256; i++) begin
      dut.im[i] = 32'hFC000000;
      dut.dm[i] = 32'h0;
    end
    for (int i = 0; i < 32; i++) dut.rf[i] = 32'h0;
  endtask

  // Stimulus
  initial begin
    int c;
    rst_on(); clr();
    dut.rf[9] = 32'hA; dut.rf[10] = 32'h14; dut.im[0] = 32'h012A4020;
    e_rst("t1_rst", 0, 0, 0);
    e_done("t1_add", 4, 1, 0, 0, 32'h4, 1, 8, 32'h1E);
    e_halt("t1_halt", 7, 32'h8, 0);
    go(10);

    rst_on(); clr();
    dut.dm[64] = 32'hDEADBEEF; dut.im[0] = 32'h8C0B0100;
    e_rst("t2_rst", 0, 0, 0);
    e_done("t2_lw", 5, 1, 4, 0, 32'h4, 1, 11, 32'hDEADBEEF);
    e_halt("t2_halt", 8, 32'h8, 0);
    go(10);

    rst_on(); clr();
    dut.rf[9] = 32'hA; dut.im[0] = 32'hAC090104;
    e_rst("t3_rst", 0, 0, 0);
    e_done("t3_sw", 4, 0, 0, 4, 32'h4, 2, 65, 32'hA);
    e_halt("t3_halt", 7, 32'h8, 0);
    go(10);

    rst_on(); clr();
    dut.im[0] = 32'h11080002;
    e_rst("t4_rst", 0, 0, 0);
    e_done("t4_beq_taken", 3, 0, 0, 0, 32'hC, 0, 0, 0);
    e_halt("t4_halt", 6, 32'h10, 0);
    go(8);

    rst_on(); clr();
    dut.rf[8] = 32'h1; dut.rf[9] = 32'h2; dut.im[0] = 32'h11090002;
    e_rst("t5_rst", 0, 0, 0);
    e_done("t5_beq_not", 3, 0, 0, 0, 32'h4, 0, 0, 0);
    e_halt("t5_halt", 6, 32'h8, 0);
    go(8);

    rst_on(); clr();
    dut.im[0] = 32'hFC000000;
    e_rst("t6_rst", 0, 0, 0);
    e_halt("t6_illegal", 3, 32'h4, 20);
    go(25);

    rst_on(); clr();
    dut.dm[64] = 32'hDEADBEEF; dut.rf[11] = 32'h1234; dut.im[0] = 32'h8C0B0100;
    e_rst("t7_rst", 1, 11, 32'h1234);
    go(3);
    rst_on();
    e_rst("t7_abort_mem", 1, 11, 32'h1234);
    go(2);

    rst_on();
    dut.rf[11] = 32'h1234;
    e_rst("t8_rst", 1, 11, 32'h1234);
    go(4);
    rst_on();
    e_rst("t8_abort_wb", 1, 11, 32'h1234);
    go(2);

    rst_on(); clr();
    dut.im[0] = 32'h08000010;
    e_rst("t9_rst", 0, 0, 0);
`ifdef MIPS_JUMP_EN
    e_done("t9_j", 3, 0, 0, 0, 32'h40, 0, 0, 0);
    e_halt("t9_halt", 6, 32'h44, 0);
`else
    e_halt("t9_j_illegal", 3, 32'h4, 0);
`endif
    go(8);

    rst_on(); clr();
    dut.rf[4] = 32'h55; dut.rf[9] = 32'h7FFFFFFF;
    dut.im[0]  = ity(6'h08, 0, 1, 16'hFFFB);
    dut.im[1]  = ity(6'h08, 0, 2, 16'h0003);
    dut.im[2]  = rty(1, 2, 3, 6'h2A);
    dut.im[3]  = rty(2, 1, 4, 6'h2A);
    dut.im[4]  = rty(2, 1, 5, 6'h22);
    dut.im[5]  = rty(1, 2, 6, 6'h24);
    dut.im[6]  = rty(1, 2, 7, 6'h25);
    dut.im[7]  = rty(1, 2, 0, 6'h20);
    dut.im[8]  = ity(6'h04, 3, 0, 16'h0005);
    dut.im[9]  = ity(6'h04, 0, 0, 16'h0002);
    dut.im[12] = rty(9, 9, 10, 6'h20);
    dut.im[13] = ity(6'h08, 9, 11, 16'h0001);
    dut.im[14] = ity(6'h2B, 2, 11, 16'h0008);
    dut.im[15] = ity(6'h23, 2, 12, 16'h0405);
    e_rst("p_rst", 0, 0, 0);
    c = 4;  e_done("p_addi_neg", c, 1, 0, 0, 32'h04, 1, 1, 32'hFFFFFFFB);
    c += 4; e_done("p_addi_pos", c, 1, 0, 0, 32'h08, 1, 2, 32'h3);
    c += 4; e_done("p_slt_true", c, 1, 0, 0, 32'h0C, 1, 3, 32'h1);
    c += 4; e_done("p_slt_false", c, 1, 0, 0, 32'h10, 1, 4, 32'h0);
    c += 4; e_done("p_sub", c, 1, 0, 0, 32'h14, 1, 5, 32'h8);
    c += 4; e_done("p_and", c, 1, 0, 0, 32'h18, 1, 6, 32'h3);
    c += 4; e_done("p_or", c, 1, 0, 0, 32'h1C, 1, 7, 32'hFFFFFFFB);
    c += 4; e_done("p_add_r0", c, 1, 0, 0, 32'h20, 1, 0, 32'h0);
    c += 3; e_done("p_beq_not", c, 0, 0, 0, 32'h24, 0, 0, 0);
    c += 3; e_done("p_beq_fwd", c, 0, 0, 0, 32'h30, 0, 0, 0);
    c += 4; e_done("p_add_wrap", c, 1, 0, 0, 32'h34, 1, 10, 32'hFFFFFFFE);
    c += 4; e_done("p_addi_wrap", c, 1, 0, 0, 32'h38, 1, 11, 32'h80000000);
    c += 4; e_done("p_sw_lowbits", c, 0, 0, c, 32'h3C, 2, 2, 32'h80000000);
    c += 5; e_done("p_lw_wrap", c, 1, c - 1, 0, 32'h40, 1, 12, 32'h80000000);
    e_halt("p_halt", c + 3, 32'h44, 20);
    go(80);
    rst_on();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
